ask_symbol_scheduler: RTL

ASK_SYMBOL_SCHEDULER -- requirements
Module: ask_symbol_scheduler

---
 rtl/ask_pkg.sv | 5 +
 rtl/ask_baud_tick.sv | 15 +
 rtl/ask_symbol_scheduler.sv | 91 +++++++++
 3 files changed

// File: rtl/ask_pkg.sv
// ask_pkg: shared state encoding and NCO width for the ASK symbol scheduler
package ask_pkg;
  localparam int PHASE_W = 32;
  typedef enum logic [1:0] {ST_IDLE, ST_PREAMBLE, ST_DATA, ST_GUARD} state_t;
endpackage

// File: rtl/ask_baud_tick.sv
// ask_baud_tick: symbol-period counter, flags the last cycle of each symbol
module ask_baud_tick #(
  parameter int unsigned BAUD_DIV = 100
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  output logic tick
);
  logic [15:0] count;
  assign tick = count == 16'(BAUD_DIV - 1);
  always_ff @(posedge clk)
    if (rst || clear || tick) count <= '0;
    else count <= count + 16'd1;
endmodule

// File: rtl/ask_symbol_scheduler.sv
// ask_symbol_scheduler: frames bytes as preamble+data symbols with a carrier-off guard
module ask_symbol_scheduler
  import ask_pkg::*;
#(
  parameter int unsigned        BAUD_DIV      = 100,
  parameter logic [7:0]         PREAMBLE      = 8'hAA,
  parameter int unsigned        PREAMBLE_BITS = 8,
  parameter int unsigned        GUARD_SYMS    = 2,
  parameter logic [PHASE_W-1:0] BASE_PHASE    = 655
) (
  input  logic               sys_clk,
  input  logic               sys_rst,
  input  logic [7:0]         s_data,
  input  logic               s_valid,
  output logic               s_ready,
  output logic               sym_bit,
  output logic               sym_stb,
  output logic               carrier_en,
  output logic [PHASE_W-1:0] phase_inc,
  output logic               busy,
  output logic               frame_done
);
  state_t     state, state_n;
  logic [7:0] idx, idx_n, sh, sh_n;
  logic       tick, clear, carrier_n;
  ask_baud_tick #(.BAUD_DIV(BAUD_DIV)) u_tick (
    .clk  (sys_clk),
    .rst  (sys_rst),
    .clear(clear),
    .tick (tick)
  );
  assign s_ready   = state == ST_IDLE || (state == ST_DATA && idx == 8'd0 && tick);
  assign clear     = state == ST_IDLE || state_n != state;
  assign carrier_n = state_n == ST_PREAMBLE || state_n == ST_DATA;
  // idx walks symbols downward: preamble bit, data bit, or remaining guard symbols
  always_comb begin
    state_n = state;
    idx_n   = idx;
    sh_n    = sh;
    case (state)
      ST_IDLE:
        if (s_valid) begin
          state_n = ST_PREAMBLE;
          idx_n   = 8'(PREAMBLE_BITS - 1);
          sh_n    = s_data;
        end
      ST_PREAMBLE:
        if (tick) begin
          state_n = idx == 8'd0 ? ST_DATA : ST_PREAMBLE;
          idx_n   = idx == 8'd0 ? 8'd7 : idx - 8'd1;
        end
      ST_DATA:
        if (tick && idx != 8'd0) idx_n = idx - 8'd1;
        else if (tick && s_valid) begin
          idx_n = 8'd7;
          sh_n  = s_data;
        end else if (tick) begin
          state_n = ST_GUARD;
          idx_n   = 8'(GUARD_SYMS - 1);
        end
      ST_GUARD:
        if (tick) begin
          state_n = idx == 8'd0 ? ST_IDLE : ST_GUARD;
          idx_n   = idx == 8'd0 ? 8'd0 : idx - 8'd1;
        end
      default: state_n = ST_IDLE;
    endcase
  end
  always_ff @(posedge sys_clk)
    if (sys_rst) begin
      state      <= ST_IDLE;
      idx        <= '0;
      sh         <= '0;
      sym_bit    <= 1'b0;
      sym_stb    <= 1'b0;
      carrier_en <= 1'b0;
      phase_inc  <= '0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      state      <= state_n;
      idx        <= idx_n;
      sh         <= sh_n;
      sym_bit    <= state_n == ST_PREAMBLE ? PREAMBLE[idx_n[2:0]] : state_n == ST_DATA && sh_n[idx_n[2:0]];
      sym_stb    <= carrier_n && (clear || tick);
      carrier_en <= carrier_n;
      phase_inc  <= carrier_n ? BASE_PHASE : '0;
      busy       <= state_n != ST_IDLE;
      frame_done <= state == ST_GUARD && state_n == ST_IDLE;
    end
endmodule
